// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared encodings for the PS/2 scan-code decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [2:0] TYPE_NONE      = 3'b000;
    localparam logic [2:0] TYPE_MAKE      = 3'b001;
    localparam logic [2:0] TYPE_EXT_MAKE  = 3'b010;
    localparam logic [2:0] TYPE_BREAK     = 3'b011;
    localparam logic [2:0] TYPE_EXT_BREAK = 3'b100;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    function automatic logic [2:0] type_from_flags(input logic ext, input logic brk);
        case ({ext, brk})
            2'b00:   return TYPE_MAKE;
            2'b10:   return TYPE_EXT_MAKE;
            2'b01:   return TYPE_BREAK;
            default: return TYPE_EXT_BREAK;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ============================================================================
// Module      : ps2_rx_frame
// Description : PS/2 line synchronizers, ps2_clk glitch filter, 11-bit frame
//               receiver with timeout. PS2_PARITY_CHECK_EN enables odd-parity
//               rejection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_prev_q, filt_prev_d;
    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_valid_q, byte_valid_d;
    logic          err_q, err_d;
    logic          fall;
    logic          dat;
    logic          frame_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q, parity_d;
`endif

    assign dat  = dat_sync_q[1];
    assign fall = filt_prev_q & ~filt_q;

    // Filtered clock only flips after FILTER_LEN consecutive differing samples
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        filt_prev_d = filt_q;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = dat & (^{shift_q, parity_q});
`else
    assign frame_ok = dat;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = '0;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d     = parity_q;
`endif
        if (state_q != ST_IDLE && !fall) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = dat;
`endif
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d      = ST_IDLE;
                    byte_valid_d = frame_ok;
                    err_d        = ~frame_ok;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            filt_prev_q  <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            filt_prev_q  <= filt_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
// ============================================================================
// Module      : ps2_scan_decoder
// Description : PS/2 keyboard scan-code decoder: frame receiver plus E0/F0/E1
//               prefix tracking. PS2_PARITY_CHECK_EN enables parity rejection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic [2:0] data_type,
    output logic       kbs_tot,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    logic [7:0] data_q, data_d;
    logic [2:0] type_q, type_d;
    logic       kbs_tot_q, kbs_tot_d;
    logic       frame_err_q, frame_err_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;

    ps2_rx_frame #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    // Frame errors leave the prefix flags untouched so a retry keeps context
    always_comb begin
        data_d      = data_q;
        type_d      = type_q;
        kbs_tot_d   = 1'b0;
        frame_err_d = rx_err;
        ext_d       = ext_q;
        brk_d       = brk_q;
        if (rx_valid) begin
            case (rx_byte)
                PFX_EXT:   ext_d = 1'b1;
                PFX_BRK:   brk_d = 1'b1;
                PFX_PAUSE: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    data_d    = rx_byte;
                    type_d    = type_from_flags(ext_q, brk_q);
                    kbs_tot_d = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= 8'h00;
            type_q      <= TYPE_NONE;
            kbs_tot_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            data_q      <= data_d;
            type_q      <= type_d;
            kbs_tot_q   <= kbs_tot_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
        end
    end

    assign data      = data_q;
    assign data_type = type_q;
    assign kbs_tot   = kbs_tot_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
// ============================================================================
// Module      : tb_ps2_scan_decoder
// Description : Scoreboard bench for ps2_scan_decoder; expectations follow
//               PS2_PARITY_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_scan_decoder;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 100;
    localparam int LATENCY        = 2 + FILTER_LEN + 2;

    typedef struct packed {
        logic       is_err;
        logic [7:0] d;
        logic [2:0] t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic [2:0] data_type;
    logic       kbs_tot;
    logic       frame_err;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    exp_t sb[$];
    logic [7:0] held_d = 8'h00;
    logic [2:0] held_t = 3'b000;

    ps2_scan_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data      (data),
        .data_type (data_type),
        .kbs_tot   (kbs_tot),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_good ? ~^b : ^b);
        send_bit(stop);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic expect_key(input logic [7:0] d, input logic [2:0] t);
        sb.push_back({1'b0, d, t});
    endtask

    task automatic expect_err();
        sb.push_back({1'b1, 8'h00, 3'b000});
    endtask

    task automatic drain();
        for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
        repeat (50) @(negedge clk);
        check("hold_data", data, held_d);
        check("hold_type", data_type, held_t);
    endtask

    always @(negedge clk) begin
        if (!rst && (kbs_tot || frame_err)) begin
            check("exclusive", {kbs_tot, frame_err} == 2'b11, 0);
            if (sb.size() == 0) begin
                check("spurious", {kbs_tot, frame_err}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("kind", frame_err, e.is_err);
                if (!e.is_err) begin
                    check("data", data, e.d);
                    check("type", data_type, e.t);
                    check("latency", cyc - last_fall_cyc, LATENCY);
                    held_d = e.d;
                    held_t = e.t;
                end else begin
                    check("err_data_held", data, held_d);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_type", data_type, 3'b000);
        check("rst_kbs", kbs_tot, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // plain make code
        expect_key(8'h5A, 3'b001);
        send_frame(8'h5A, 1'b1, 1'b1);
        drain();

        // extended break: only the final byte strobes
        expect_key(8'h75, 3'b100);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        drain();

        // break then make
        expect_key(8'h1C, 3'b011);
        expect_key(8'h23, 3'b001);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h23, 1'b1, 1'b1);
        drain();

        // bad parity
`ifdef PS2_PARITY_CHECK_EN
        expect_err();
`else
        expect_key(8'h5A, 3'b001);
`endif
        send_frame(8'h5A, 1'b0, 1'b1);
        drain();

        // E1 clears a pending E0
        expect_key(8'h5A, 3'b001);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hE1, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        drain();

        // stop-bit error keeps ext flag
        expect_err();
        expect_key(8'h75, 3'b010);
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h75, 1'b1, 1'b1);
        drain();

        // timeout after start + 4 data bits
        expect_err();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (TIMEOUT_CYCLES * 12 / 10) @(negedge clk);
        expect_key(8'h1C, 3'b001);
        send_frame(8'h1C, 1'b1, 1'b1);
        drain();

        // reset mid-frame after 5th data bit
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_type", data_type, 3'b000);
        rst = 1'b0;
        ps2_data = 1'b1;
        held_d = 8'h00;
        held_t = 3'b000;
        repeat (30) @(negedge clk);
        check("post_rst_kbs", kbs_tot, 1'b0);

        // 50 ns glitch with data low must not start a frame
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        #50;
        ps2_clk  = 1'b1;
        repeat (50) @(negedge clk);
        ps2_data = 1'b1;
        repeat (50) @(negedge clk);
        expect_key(8'h23, 3'b001);
        send_frame(8'h23, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
